// File: rtl/cpu_pkg.sv
// Shared CPU constants, opcode encoding and fetch FSM state type.
package cpu_pkg;

    localparam int DATA_WIDTH        = 11;
    localparam int INSTRUCTION_WIDTH = 16;
    localparam int OP_WIDTH          = INSTRUCTION_WIDTH - DATA_WIDTH;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_HLT = 5'd0,
        OP_LDA = 5'd1,
        OP_STA = 5'd2,
        OP_LDI = 5'd3,
        OP_ADD = 5'd4,
        OP_SUB = 5'd5,
        OP_AND = 5'd6,
        OP_OR  = 5'd7,
        OP_XOR = 5'd8,
        OP_NOT = 5'd9,
        OP_SHL = 5'd10,
        OP_SHR = 5'd11,
        OP_BEQ = 5'd12,
        OP_BNE = 5'd13,
        OP_JMP = 5'd14
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load, increment with natural wrap, async active-low reset.
module pc_counter #(
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_inc
);

    logic [WIDTH-1:0] r_pc;

    assign o_pc     = r_pc;
    assign o_pc_inc = r_pc + {{(WIDTH-1){1'b0}}, 1'b1};

    // PC register; load has priority over increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= o_pc_inc;
        end else begin
            r_pc <= r_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/VALID/HALT sequencer feeding the decoder.
// Optional one-entry prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH        = cpu_pkg::DATA_WIDTH,
    parameter int INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH
) (
    input  logic                                    clock_in,
    input  logic                                    reset_in,
    output logic                                    imem_req_out,
    output logic [DATA_WIDTH-1:0]                   imem_addr_out,
    input  logic                                    imem_ack_in,
    input  logic [INSTRUCTION_WIDTH-1:0]            imem_data_in,
    output logic                                    instr_valid_out,
    output logic [INSTRUCTION_WIDTH-DATA_WIDTH-1:0] op_code_out,
    output logic [DATA_WIDTH-1:0]                   operand_out,
    input  logic                                    pc_wr_in,
    input  logic                                    branch_in,
    output logic                                    halted_out
);

    localparam int OPW = INSTRUCTION_WIDTH - DATA_WIDTH;

    fetch_state_t                 r_state;
    logic [INSTRUCTION_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0]        w_pc;
    logic [DATA_WIDTH-1:0]        w_pc_inc;
    logic                         w_is_hlt;
    logic                         w_adv;
    logic                         w_pc_load;
    logic                         w_pc_inc_en;

    assign op_code_out     = r_ir[INSTRUCTION_WIDTH-1:DATA_WIDTH];
    assign operand_out     = r_ir[DATA_WIDTH-1:0];
    assign w_is_hlt        = (op_code_out == {OPW{1'b0}});
    assign instr_valid_out = (r_state == ST_VALID);
    assign halted_out      = (r_state == ST_HALT);

    // PC update controls: only a non-HLT held instruction may advance the PC
    always_comb begin
        w_adv       = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_inc_en = 1'b0;
        if ((r_state == ST_VALID) && pc_wr_in && !w_is_hlt) begin
            w_adv       = 1'b1;
            w_pc_load   = branch_in;
            w_pc_inc_en = !branch_in;
        end else begin
            w_adv       = 1'b0;
        end
    end

    pc_counter #(.WIDTH(DATA_WIDTH)) u_pc (
        .i_clk      (clock_in),
        .i_rst_n    (reset_in),
        .i_load     (w_pc_load),
        .i_load_val (operand_out),
        .i_inc      (w_pc_inc_en),
        .o_pc       (w_pc),
        .o_pc_inc   (w_pc_inc)
    );

`ifdef FETCH_PREFETCH_EN
    logic [INSTRUCTION_WIDTH-1:0] r_buf;
    logic                         r_buf_full;
    logic                         r_flush;
    logic [DATA_WIDTH-1:0]        r_flush_addr;
    logic                         w_pf_req;

    // A flushed prefetch keeps its original address until its ack retires it
    assign w_pf_req      = (r_state == ST_VALID) && !r_buf_full && !w_is_hlt;
    assign imem_req_out  = reset_in && ((r_state == ST_FETCH) || w_pf_req);
    assign imem_addr_out = r_flush ? r_flush_addr :
                           ((r_state == ST_VALID) ? w_pc_inc : w_pc);

    // Fetch sequencer with prefetch buffer
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state      <= ST_FETCH;
            r_ir         <= {INSTRUCTION_WIDTH{1'b0}};
            r_buf        <= {INSTRUCTION_WIDTH{1'b0}};
            r_buf_full   <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_addr <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack_in && r_flush) begin
                        r_flush <= 1'b0;
                    end else if (imem_ack_in) begin
                        r_ir    <= imem_data_in;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_is_hlt) begin
                        r_state <= ST_HALT;
                    end else if (w_adv && branch_in) begin
                        r_buf_full   <= 1'b0;
                        r_flush      <= w_pf_req && !imem_ack_in;
                        r_flush_addr <= w_pc_inc;
                        r_state      <= ST_FETCH;
                    end else if (w_adv) begin
                        if (r_buf_full) begin
                            r_ir       <= r_buf;
                            r_buf_full <= 1'b0;
                        end else if (imem_ack_in) begin
                            r_ir <= imem_data_in;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else if (w_pf_req && imem_ack_in) begin
                        r_buf      <= imem_data_in;
                        r_buf_full <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end
`else
    // Request is gated by reset so it drops the moment reset asserts
    assign imem_req_out  = reset_in && (r_state == ST_FETCH);
    assign imem_addr_out = w_pc;

    // Fetch sequencer
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= ST_FETCH;
            r_ir    <= {INSTRUCTION_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack_in) begin
                        r_ir    <= imem_data_in;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_is_hlt) begin
                        r_state <= ST_HALT;
                    end else if (w_adv) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default build, no prefetch).
module tb_fetch_unit;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        imem_req_out;
    logic [10:0] imem_addr_out;
    logic        imem_ack_in;
    logic [15:0] imem_data_in;
    logic        instr_valid_out;
    logic [4:0]  op_code_out;
    logic [10:0] operand_out;
    logic        pc_wr_in;
    logic        branch_in;
    logic        halted_out;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_unit dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ack_in     (imem_ack_in),
        .imem_data_in    (imem_data_in),
        .instr_valid_out (instr_valid_out),
        .op_code_out     (op_code_out),
        .operand_out     (operand_out),
        .pc_wr_in        (pc_wr_in),
        .branch_in       (branch_in),
        .halted_out      (halted_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock_in);
        #1;
    endtask

    task automatic deliver(input logic [15:0] d);
        imem_ack_in  = 1'b1;
        imem_data_in = d;
        cyc();
        imem_ack_in  = 1'b0;
        imem_data_in = 16'h0000;
    endtask

    task automatic advance(input logic br);
        pc_wr_in  = 1'b1;
        branch_in = br;
        cyc();
        pc_wr_in  = 1'b0;
        branch_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_in     = 1'b0;
        imem_ack_in  = 1'b0;
        imem_data_in = 16'h0000;
        pc_wr_in     = 1'b0;
        branch_in    = 1'b0;
        cyc();
        cyc();
        chk("rst_req",    32'(imem_req_out),    32'd0);
        chk("rst_valid",  32'(instr_valid_out), 32'd0);
        chk("rst_halted", 32'(halted_out),      32'd0);
        chk("rst_op",     32'(op_code_out),     32'd0);
        chk("rst_opnd",   32'(operand_out),     32'd0);

        reset_in = 1'b1;
        #1;
        chk("first_req",  32'(imem_req_out),  32'd1);
        chk("first_addr", 32'(imem_addr_out), 32'd0);

        deliver(16'h1805);
        chk("ldi_valid", 32'(instr_valid_out), 32'd1);
        chk("ldi_op",    32'(op_code_out),     32'd3);
        chk("ldi_opnd",  32'(operand_out),     32'd5);
        chk("ldi_noreq", 32'(imem_req_out),    32'd0);

        branch_in = 1'b1;
        cyc();
        branch_in = 1'b0;
        chk("br_alone_valid", 32'(instr_valid_out), 32'd1);
        chk("br_alone_noreq", 32'(imem_req_out),    32'd0);

        advance(1'b0);
        chk("seq_req",   32'(imem_req_out),    32'd1);
        chk("seq_addr",  32'(imem_addr_out),   32'd1);
        chk("seq_valid", 32'(instr_valid_out), 32'd0);

        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wait_addr",  32'(imem_addr_out),   32'd1);
            chk("wait_req",   32'(imem_req_out),    32'd1);
            chk("wait_valid", 32'(instr_valid_out), 32'd0);
        end
        deliver(16'h6064);
        chk("beq_valid", 32'(instr_valid_out), 32'd1);
        chk("beq_op",    32'(op_code_out),     32'd12);
        chk("beq_opnd",  32'(operand_out),     32'd100);

        advance(1'b1);
        chk("br_req",  32'(imem_req_out),  32'd1);
        chk("br_addr", 32'(imem_addr_out), 32'd100);

        advance(1'b0);
        chk("pcwr_fetch_addr",  32'(imem_addr_out),   32'd100);
        chk("pcwr_fetch_valid", 32'(instr_valid_out), 32'd0);

        deliver(16'h2007);
        chk("add_op",   32'(op_code_out), 32'd4);
        chk("add_opnd", 32'(operand_out), 32'd7);

        deliver(16'hFFFF);
        chk("stray_ack_op",    32'(op_code_out),     32'd4);
        chk("stray_ack_opnd",  32'(operand_out),     32'd7);
        chk("stray_ack_valid", 32'(instr_valid_out), 32'd1);

        advance(1'b0);
        chk("nobr_addr", 32'(imem_addr_out), 32'd101);

        deliver(16'h77FF);
        chk("jmp_op",   32'(op_code_out), 32'd14);
        chk("jmp_opnd", 32'(operand_out), 32'd2047);
        advance(1'b1);
        chk("jmp_addr", 32'(imem_addr_out), 32'd2047);

        deliver(16'h1805);
        advance(1'b0);
        chk("wrap_req",  32'(imem_req_out),  32'd1);
        chk("wrap_addr", 32'(imem_addr_out), 32'd0);

        deliver(16'h0000);
        chk("hlt_valid",  32'(instr_valid_out), 32'd1);
        chk("hlt_halted", 32'(halted_out),      32'd0);
        chk("hlt_op",     32'(op_code_out),     32'd0);
        pc_wr_in = 1'b1;
        cyc();
        pc_wr_in = 1'b0;
        chk("halt_halted", 32'(halted_out),      32'd1);
        chk("halt_valid",  32'(instr_valid_out), 32'd0);
        chk("halt_req",    32'(imem_req_out),    32'd0);
        cyc();
        cyc();
        chk("halt_hold_req",    32'(imem_req_out), 32'd0);
        chk("halt_hold_halted", 32'(halted_out),   32'd1);

        reset_in = 1'b0;
        cyc();
        reset_in = 1'b1;
        #1;
        chk("rst2_req",  32'(imem_req_out),  32'd1);
        chk("rst2_addr", 32'(imem_addr_out), 32'd0);
        deliver(16'h1805);
        advance(1'b0);
        chk("pre_rst_addr", 32'(imem_addr_out), 32'd1);
        cyc();
        reset_in = 1'b0;
        #1;
        chk("mid_rst_req",    32'(imem_req_out),    32'd0);
        chk("mid_rst_valid",  32'(instr_valid_out), 32'd0);
        chk("mid_rst_halted", 32'(halted_out),      32'd0);
        cyc();
        reset_in = 1'b1;
        #1;
        chk("restart_req",  32'(imem_req_out),  32'd1);
        chk("restart_addr", 32'(imem_addr_out), 32'd0);
        deliver(16'h1805);
        chk("restart_valid", 32'(instr_valid_out), 32'd1);
        chk("restart_op",    32'(op_code_out),     32'd3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
